// File: rtl/dmem_responder_pkg.sv
// Cache<->memory bus types shared by the D-cache/I-cache controllers and the memory responder.
// Tags are 4 bits with 0 reserved for "no request / nothing returning".
package dmem_responder_pkg;

  localparam int MEM_TAG_W = 4;
  localparam int BLOCK_W   = 64;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } bus_command_e;

  function automatic logic [MEM_TAG_W-1:0] tag_after(input logic [MEM_TAG_W-1:0] tag);
    return (tag == '1) ? MEM_TAG_W'(1) : tag + 1'b1;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Cache<->memory bus: the cache controller is the master, the memory responder the slave.
// Response is same-cycle combinational; tag/data return registered, a fixed latency later.
interface dmem_responder_if;
  import dmem_responder_pkg::*;

  bus_command_e         proc2mem_command;
  logic [31:0]          proc2mem_addr;
  logic [BLOCK_W-1:0]   proc2mem_data;
  logic [MEM_TAG_W-1:0] mem2proc_response;
  logic [BLOCK_W-1:0]   mem2proc_data;
  logic [MEM_TAG_W-1:0] mem2proc_tag;

  modport master (
    output proc2mem_command, proc2mem_addr, proc2mem_data,
    input  mem2proc_response, mem2proc_data, mem2proc_tag
  );

  modport slave (
    input  proc2mem_command, proc2mem_addr, proc2mem_data,
    output mem2proc_response, mem2proc_data, mem2proc_tag
  );

endinterface

// File: rtl/dmem_responder_mem_return_queue.sv
// In-flight load slots: each returns its tag/data exactly LATENCY cycles after the push.
// Pushes are gated by the caller using full/retire; a retiring slot may be refilled in the same cycle.
module dmem_responder_mem_return_queue
  import dmem_responder_pkg::*;
#(
  parameter int LATENCY     = 4,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 push,
  input  logic [MEM_TAG_W-1:0] push_tag,
  input  logic [BLOCK_W-1:0]   push_data,
  output logic                 full,
  output logic                 retire,
  output logic [MEM_TAG_W-1:0] ret_tag,
  output logic [BLOCK_W-1:0]   ret_data
);

  localparam int SLOT_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam bit BYPASS = (LATENCY == 1);
  // countdown is the number of whole cycles a slot waits before its retire cycle
  localparam logic [3:0] CD_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  typedef struct packed {
    logic                 valid;
    logic [MEM_TAG_W-1:0] tag;
    logic [BLOCK_W-1:0]   data;
    logic [3:0]           countdown;
  } slot_t;

  slot_t             slots [QUEUE_DEPTH];
  logic [SLOT_W-1:0] ret_idx;
  logic [SLOT_W-1:0] free_idx;
  logic              free_found;
  int                occ;

  always_comb begin
    retire     = 1'b0;
    ret_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    occ        = 0;
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      if (slots[i].valid) occ = occ + 1;
      if (slots[i].valid && slots[i].countdown == 4'd0) begin
        retire  = 1'b1;
        ret_idx = SLOT_W'(i);
      end
    end
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      if (!free_found && (!slots[i].valid || (retire && ret_idx == SLOT_W'(i)))) begin
        free_found = 1'b1;
        free_idx   = SLOT_W'(i);
      end
    end
    full = (occ >= QUEUE_DEPTH);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) slots[i].valid <= 1'b0;
      ret_tag  <= '0;
      ret_data <= '0;
    end else begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        if (slots[i].valid) slots[i].countdown <= slots[i].countdown - 4'd1;
      end
      if (retire) slots[ret_idx].valid <= 1'b0;
      if (push && !BYPASS && free_found) begin
        slots[free_idx] <= '{valid: 1'b1, tag: push_tag, data: push_data, countdown: CD_INIT};
      end

      if (BYPASS && push) begin
        ret_tag  <= push_tag;
        ret_data <= push_data;
      end else if (retire) begin
        ret_tag  <= slots[ret_idx].tag;
        ret_data <= slots[ret_idx].data;
      end else begin
        ret_tag  <= '0;
        ret_data <= '0;
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Tagged fixed-latency data memory answering the cache bus; tag issued same cycle, loads return LATENCY later.
// Stores always accepted; loads refused (response 0) while every return slot is busy and none retires.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int MEM_BLOCKS  = 8192,
  parameter int LATENCY     = 4,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  dmem_responder_if.slave  bus
);

  localparam int IDX_W = $clog2(MEM_BLOCKS);

  logic [BLOCK_W-1:0]   mem [MEM_BLOCKS];
  logic [IDX_W-1:0]     idx;
  logic [MEM_TAG_W-1:0] next_tag;
  logic                 is_load;
  logic                 is_store;
  logic                 accept_load;
  logic                 accept;
  logic                 q_full;
  logic                 q_retire;
  logic [MEM_TAG_W-1:0] q_ret_tag;
  logic [BLOCK_W-1:0]   q_ret_data;

  // Offset bits and everything above the index field alias onto the same block.
  assign idx = bus.proc2mem_addr[3 +: IDX_W];
  wire unused_addr_bits = ^{bus.proc2mem_addr[2:0], bus.proc2mem_addr[31:3+IDX_W]};

  always_comb begin
    is_load     = !reset && (bus.proc2mem_command == BUS_LOAD);
    is_store    = !reset && (bus.proc2mem_command == BUS_STORE);
    accept_load = is_load && (!q_full || q_retire);
    accept      = accept_load || is_store;
    bus.mem2proc_response = accept ? next_tag : '0;
  end

  // The array has no reset so preloaded contents survive a reset.
  always_ff @(posedge clock) begin
    if (is_store) mem[idx] <= bus.proc2mem_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      next_tag <= MEM_TAG_W'(1);
    end else if (accept) begin
      next_tag <= tag_after(next_tag);
    end
  end

  dmem_responder_mem_return_queue #(
    .LATENCY     (LATENCY),
    .QUEUE_DEPTH (QUEUE_DEPTH)
  ) u_return_queue (
    .clock     (clock),
    .reset     (reset),
    .push      (accept_load),
    .push_tag  (next_tag),
    .push_data (mem[idx]),
    .full      (q_full),
    .retire    (q_retire),
    .ret_tag   (q_ret_tag),
    .ret_data  (q_ret_data)
  );

  assign bus.mem2proc_tag  = q_ret_tag;
  assign bus.mem2proc_data = q_ret_data;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized plus directed bench for dmem_responder against a cycle-indexed return-schedule model.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  localparam int MEM_BLOCKS  = 8192;
  localparam int LATENCY     = 4;
  localparam int QUEUE_DEPTH = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  dmem_responder_if bus ();

  dmem_responder #(
    .MEM_BLOCKS  (MEM_BLOCKS),
    .LATENCY     (LATENCY),
    .QUEUE_DEPTH (QUEUE_DEPTH)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          due;
    logic [3:0]  tag;
    logic [63:0] data;
  } ret_t;

  ret_t        pend [$];
  logic [63:0] model_mem [int];
  int          model_tag = 1;
  int          cyc = 0;
  bit          out_valid = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [3:0]  r;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  // One bus cycle: check returning outputs, drive, check response, advance the model.
  task automatic step(input logic rst, input bus_command_e cmd, input logic [31:0] addr,
                      input logic [63:0] data, output logic [3:0] resp);
    logic [3:0]  et;
    logic [63:0] ed;
    int          bidx;
    int          busy;
    bit          acc;
    if (out_valid) begin
      et = '0;
      ed = '0;
      foreach (pend[i]) if (pend[i].due == cyc) begin
        et = pend[i].tag;
        ed = pend[i].data;
      end
      check("ret_tag", 64'(bus.mem2proc_tag), 64'(et));
      check("ret_data", bus.mem2proc_data, ed);
    end
    reset                = rst;
    bus.proc2mem_command = cmd;
    bus.proc2mem_addr    = addr;
    bus.proc2mem_data    = data;
    #1;
    bidx = int'((addr >> 3) % MEM_BLOCKS);
    busy = 0;
    foreach (pend[i]) if (pend[i].due > cyc + 1) busy++;
    acc  = !rst && (cmd == BUS_STORE || (cmd == BUS_LOAD && busy < QUEUE_DEPTH));
    resp = bus.mem2proc_response;
    check("response", 64'(resp), acc ? 64'(model_tag) : 64'd0);
    if (acc) begin
      if (cmd == BUS_STORE) model_mem[bidx] = data;
      else pend.push_back('{due: cyc + LATENCY, tag: 4'(model_tag), data: model_mem[bidx]});
      model_tag = (model_tag == 15) ? 1 : model_tag + 1;
    end
    if (rst) begin
      pend.delete();
      model_tag = 1;
    end
    @(posedge clock);
    #1;
    cyc++;
    out_valid = 1;
    while (pend.size() > 0 && pend[0].due < cyc) void'(pend.pop_front());
  endtask

  task automatic idle(input int n);
    logic [3:0] d;
    for (int k = 0; k < n; k++) step(1'b0, BUS_NONE, 32'd0, 64'd0, d);
  endtask

  task automatic pulse_reset();
    logic [3:0] d;
    step(1'b1, BUS_NONE, 32'd0, 64'd0, d);
  endtask

  initial begin
    bus.proc2mem_command = BUS_NONE;
    bus.proc2mem_addr    = '0;
    bus.proc2mem_data    = '0;
    @(posedge clock);
    #1;
    pulse_reset();
    pulse_reset();

    // Preload blocks 0..15; block 5 gets the known pattern.
    for (int b = 0; b < 16; b++) begin
      step(1'b0, BUS_STORE, 32'(b << 3),
           (b == 5) ? 64'hDEAD_BEEF_0123_4567 : {$urandom, $urandom}, r);
    end
    pulse_reset();

    // Single load latency and data.
    step(1'b0, BUS_LOAD, 32'h28, 64'd0, r);
    check("t1_resp", 64'(r), 64'd1);
    idle(3);
    check("t1_tag", 64'(bus.mem2proc_tag), 64'd1);
    check("t1_data", bus.mem2proc_data, 64'hDEAD_BEEF_0123_4567);
    idle(3);

    // Store then load of the same block on consecutive cycles.
    pulse_reset();
    step(1'b0, BUS_STORE, 32'h40, 64'h1111, r);
    check("t2_store_resp", 64'(r), 64'd1);
    step(1'b0, BUS_LOAD, 32'h40, 64'd0, r);
    check("t2_load_resp", 64'(r), 64'd2);
    idle(3);
    check("t2_tag", 64'(bus.mem2proc_tag), 64'd2);
    check("t2_data", bus.mem2proc_data, 64'h1111);
    idle(3);

    // Queue full refusal and same-cycle retire acceptance.
    pulse_reset();
    step(1'b0, BUS_LOAD, 32'h28, 64'd0, r);
    check("t3_resp0", 64'(r), 64'd1);
    step(1'b0, BUS_LOAD, 32'h30, 64'd0, r);
    check("t3_resp1", 64'(r), 64'd2);
    step(1'b0, BUS_LOAD, 32'h38, 64'd0, r);
    check("t3_refused", 64'(r), 64'd0);
    step(1'b0, BUS_LOAD, 32'h38, 64'd0, r);
    check("t3_retry", 64'(r), 64'd3);
    idle(6);

    // Tag wrap 15 -> 1 over 16 accepted stores.
    pulse_reset();
    for (int k = 0; k < 16; k++) begin
      step(1'b0, BUS_STORE, 32'((16 + k) << 3), {$urandom, $urandom}, r);
      check("t4_tag_seq", 64'(r), 64'((k % 15) + 1));
    end

    // Reset drops in-flight loads; memory survives.
    pulse_reset();
    step(1'b0, BUS_LOAD, 32'h28, 64'd0, r);
    step(1'b0, BUS_LOAD, 32'h30, 64'd0, r);
    pulse_reset();
    idle(6);
    step(1'b0, BUS_LOAD, 32'h28, 64'd0, r);
    check("t5_first_resp", 64'(r), 64'd1);
    idle(3);
    check("t5_data", bus.mem2proc_data, 64'hDEAD_BEEF_0123_4567);
    idle(2);

    // Aliased address returns the same block; idle bus is all zero.
    step(1'b0, BUS_LOAD, 32'h0002_0028, 64'd0, r);
    idle(3);
    check("t6_alias_data", bus.mem2proc_data, 64'hDEAD_BEEF_0123_4567);
    idle(2);
    check("t6_idle_tag", 64'(bus.mem2proc_tag), 64'd0);
    check("t6_idle_data", bus.mem2proc_data, 64'd0);

    // Random traffic over the preloaded blocks with aliasing and occasional reset.
    for (int k = 0; k < 600; k++) begin
      int            sel;
      bus_command_e  cmd;
      logic [31:0]   addr;
      sel  = int'($urandom_range(0, 9));
      cmd  = (sel < 2) ? BUS_NONE : (sel < 7) ? BUS_LOAD : BUS_STORE;
      addr = ($urandom & 32'hFFFF_0007) | 32'($urandom_range(0, 15) << 3);
      step(($urandom_range(0, 59) == 0), cmd, addr, {$urandom, $urandom}, r);
    end
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
